// File: rtl/player_pos_ctrl_pkg.sv
// Shared types, widths and default court/motion constants for the player motion controller.
// The clamp helper keeps signed intermediate results inside the court limits.
package player_pos_ctrl_pkg;

  localparam int POS_W  = 12;
  localparam int VY_W   = 8;
  localparam int CALC_W = 13;

  localparam int TICK_DIV_DEF = 1083333;
  localparam int X_START_DEF  = 180;
  localparam int X_MIN_DEF    = 0;
  localparam int X_MAX_DEF    = 440;
  localparam int Y_GROUND_DEF = 325;
  localparam int STEP_X_DEF   = 4;
  localparam int JUMP_V0_DEF  = 16;
  localparam int GRAVITY_DEF  = 1;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_AIR    = 2'd1,
    ST_LAND   = 2'd2
  } vstate_t;

  function automatic logic [POS_W-1:0] clamp_pos(
    input logic signed [CALC_W-1:0] v,
    input logic signed [CALC_W-1:0] lo,
    input logic signed [CALC_W-1:0] hi
  );
    logic signed [CALC_W-1:0] r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return POS_W'(r);
  endfunction

endpackage

// File: rtl/player_pos_ctrl_if.sv
// Request levels in, sprite position and status out, for one player controller.
interface player_pos_ctrl_if;

  logic                                   move_left;
  logic                                   move_right;
  logic                                   jump;
  logic [player_pos_ctrl_pkg::POS_W-1:0]  posx;
  logic [player_pos_ctrl_pkg::POS_W-1:0]  posy;
  logic                                   in_air;
  logic                                   tick;

  modport master (
    output move_left, move_right, jump,
    input  posx, posy, in_air, tick
  );

  modport slave (
    input  move_left, move_right, jump,
    output posx, posy, in_air, tick
  );

endinterface

// File: rtl/player_pos_ctrl_tick_gen.sv
// Free-running frame-rate divider: one-cycle tick when the count reaches TICK_DIV-1.
module motion_tick_gen #(
  parameter int TICK_DIV = player_pos_ctrl_pkg::TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // divider count, wrapping after the tick cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/player_pos_ctrl.sv
// Per-player motion controller: constant-step clamped x motion and a ballistic jump FSM,
// both advanced once per motion tick.
module player_pos_ctrl
  import player_pos_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int X_START  = X_START_DEF,
  parameter int X_MIN    = X_MIN_DEF,
  parameter int X_MAX    = X_MAX_DEF,
  parameter int Y_GROUND = Y_GROUND_DEF,
  parameter int STEP_X   = STEP_X_DEF,
  parameter int JUMP_V0  = JUMP_V0_DEF,
  parameter int GRAVITY  = GRAVITY_DEF
) (
  input  logic               clk,
  input  logic               rst,
  player_pos_ctrl_if.slave   bus
);

  localparam logic signed [CALC_W-1:0] XMIN_C = CALC_W'(X_MIN);
  localparam logic signed [CALC_W-1:0] XMAX_C = CALC_W'(X_MAX);
  localparam logic signed [CALC_W-1:0] YGND_C = CALC_W'(Y_GROUND);

  vstate_t                   state_r, state_s;
  logic signed [VY_W-1:0]    vy_r, vy_s;
  logic [POS_W-1:0]          posx_r, posx_s;
  logic [POS_W-1:0]          posy_r, posy_s;
  logic                      in_air_r;
  logic                      tick_s;
  logic signed [CALC_W-1:0]  x_dec_s, x_inc_s, y_next_s, vy_ext_s;

  motion_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  // 13-bit signed candidates so a step below X_MIN clamps instead of wrapping
  assign vy_ext_s = {{(CALC_W-VY_W){vy_r[VY_W-1]}}, vy_r};
  assign x_dec_s  = $signed({1'b0, posx_r}) - CALC_W'(STEP_X);
  assign x_inc_s  = $signed({1'b0, posx_r}) + CALC_W'(STEP_X);
  assign y_next_s = $signed({1'b0, posy_r}) - vy_ext_s;

  // next-state and datapath, only advancing on tick cycles
  always_comb begin
    state_s = state_r;
    vy_s    = vy_r;
    posx_s  = posx_r;
    posy_s  = posy_r;
    if (tick_s) begin
      if (bus.move_left && !bus.move_right) begin
        posx_s = clamp_pos(x_dec_s, XMIN_C, XMAX_C);
      end else if (bus.move_right && !bus.move_left) begin
        posx_s = clamp_pos(x_inc_s, XMIN_C, XMAX_C);
      end else begin
        posx_s = posx_r;
      end
      case (state_r)
        ST_GROUND: begin
          if (bus.jump) begin
            state_s = ST_AIR;
            vy_s    = VY_W'(JUMP_V0);
          end else begin
            state_s = ST_GROUND;
          end
        end
        ST_AIR: begin
          // landing snaps to the ground line so there is never an overshoot
          if (y_next_s >= YGND_C) begin
            posy_s  = POS_W'(Y_GROUND);
            vy_s    = {VY_W{1'b0}};
            state_s = ST_LAND;
          end else begin
            posy_s  = POS_W'(y_next_s);
            vy_s    = vy_r - VY_W'(GRAVITY);
          end
        end
        ST_LAND: begin
          if (!bus.jump) begin
            state_s = ST_GROUND;
          end else begin
            state_s = ST_LAND;
          end
        end
        default: begin
          state_s = ST_GROUND;
          vy_s    = {VY_W{1'b0}};
          posy_s  = POS_W'(Y_GROUND);
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // state, velocity and position registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_GROUND;
      vy_r     <= {VY_W{1'b0}};
      posx_r   <= POS_W'(X_START);
      posy_r   <= POS_W'(Y_GROUND);
      in_air_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      vy_r     <= vy_s;
      posx_r   <= posx_s;
      posy_r   <= posy_s;
      in_air_r <= (state_s == ST_AIR);
    end
  end

  assign bus.posx   = posx_r;
  assign bus.posy   = posy_r;
  assign bus.in_air = in_air_r;
  assign bus.tick   = tick_s;

endmodule

// File: tb/tb_player_pos_ctrl.sv
// Randomized bench for player_pos_ctrl against a closed-form motion model.
module tb_player_pos_ctrl;

  localparam int TD  = 4;
  localparam int XS  = 180;
  localparam int XLO = 0;
  localparam int XHI = 440;
  localparam int YG  = 325;
  localparam int SX  = 4;
  localparam int V0  = 16;
  localparam int G   = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  player_pos_ctrl_if pif ();

  player_pos_ctrl #(.TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif.slave)
  );

  int checks   = 0;
  int failures = 0;

  int m_cnt, mx, my, m_phase, m_n;
  bit m_tick_edge;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; mx = XS; my = YG; m_phase = 0; m_n = 0;
  endtask

  // phase 0 standing, 1 airborne (m_n ticks since take-off), 2 landed awaiting release
  task automatic model_tick(input bit l, input bit r, input bit j);
    int y;
    if (l && !r) mx = (mx - SX < XLO) ? XLO : mx - SX;
    else if (r && !l) mx = (mx + SX > XHI) ? XHI : mx + SX;
    if (m_phase == 0) begin
      if (j) begin m_phase = 1; m_n = 0; end
    end else if (m_phase == 1) begin
      m_n++;
      y = YG - (V0 * m_n - (G * m_n * (m_n - 1)) / 2);
      if (y >= YG) begin my = YG; m_phase = 2; end
      else my = y;
    end else begin
      if (!j) m_phase = 0;
    end
  endtask

  task automatic check_outputs();
    check_val("posx", 32'(pif.posx), mx);
    check_val("posy", 32'(pif.posy), my);
    check_val("in_air", 32'(pif.in_air), (m_phase == 1) ? 1 : 0);
    check_val("tick", 32'(pif.tick), (m_cnt == TD - 1) ? 1 : 0);
  endtask

  task automatic drive(input bit l, input bit r, input bit j);
    pif.move_left = l; pif.move_right = r; pif.jump = j;
  endtask

  task automatic step();
    bit l, r, j;
    l = pif.move_left; r = pif.move_right; j = pif.jump;
    @(posedge clk);
    m_tick_edge = (m_cnt == TD - 1);
    if (m_tick_edge) model_tick(l, r, j);
    m_cnt = (m_cnt + 1) % TD;
    #1;
    check_outputs();
  endtask

  // levels are presented on the tick cycle only; other cycles carry random noise
  task automatic run_tick(input bit l, input bit r, input bit j);
    int guard = 0;
    do begin
      if (m_cnt == TD - 1) drive(l, r, j);
      else drive(1'($urandom), 1'($urandom), 1'($urandom));
      step();
      guard++;
    end while (!m_tick_edge && guard < 2 * TD);
    if (!m_tick_edge) check_val("tick_timeout", 0, 1);
  endtask

  initial begin
    int cyc, jumps, px0;
    bit prev_air;
    drive(1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;

    cyc = 1;
    while (!pif.tick && cyc < 10) begin
      step();
      cyc++;
    end
    check_val("first_tick_cycle", cyc, 4);

    repeat (10) run_tick(1'b0, 1'b1, 1'b0);
    check_val("right10", 32'(pif.posx), 220);
    repeat (5) run_tick(1'b1, 1'b1, 1'b0);
    check_val("both_hold", 32'(pif.posx), 220);
    repeat (60) run_tick(1'b1, 1'b0, 1'b0);
    check_val("left_clamp", 32'(pif.posx), 0);
    repeat (120) run_tick(1'b0, 1'b1, 1'b0);
    check_val("right_clamp", 32'(pif.posx), 440);

    run_tick(1'b0, 1'b0, 1'b1);
    check_val("entry_air", 32'(pif.in_air), 1);
    check_val("entry_posy", 32'(pif.posy), 325);
    for (int k = 1; k <= 33; k++) begin
      run_tick(1'b0, 1'b0, 1'b0);
      if (k == 1)  check_val("jump_t1", 32'(pif.posy), 309);
      if (k == 2)  check_val("jump_t2", 32'(pif.posy), 294);
      if (k == 16) check_val("apex16", 32'(pif.posy), 189);
      if (k == 17) check_val("apex17", 32'(pif.posy), 189);
      if (k == 32) check_val("air32", 32'(pif.in_air), 1);
      if (k == 33) begin
        check_val("land_posy", 32'(pif.posy), 325);
        check_val("land_air", 32'(pif.in_air), 0);
      end
    end

    run_tick(1'b0, 1'b0, 1'b0);
    jumps = 0;
    prev_air = 1'b0;
    repeat (80) begin
      run_tick(1'b0, 1'b0, 1'b1);
      if (pif.in_air && !prev_air) jumps++;
      prev_air = pif.in_air;
    end
    check_val("hold_jump_once", jumps, 1);
    run_tick(1'b0, 1'b0, 1'b0);
    run_tick(1'b0, 1'b0, 1'b1);
    check_val("rejump", 32'(pif.in_air), 1);

    px0 = int'(pif.posx);
    repeat (5) run_tick(1'b1, 1'b0, 1'b1);
    check_val("air_move_x", 32'(pif.posx), px0 - 20);
    check_val("air_move_inair", 32'(pif.in_air), 1);

    rst = 1'b0;
    #2;
    check_val("async_posy", 32'(pif.posy), 325);
    check_val("async_air", 32'(pif.in_air), 0);
    check_val("async_posx", 32'(pif.posx), 180);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    repeat (400) begin
      run_tick(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
